psk_frame_sequencer: RTL

//  Reads a frame of DATA_WIDTH-bit words from a single-port BRAM and emits a continuous

---
 rtl/psk_seq_pkg.sv | 23 ++
 rtl/psk_sym_timer.sv | 26 ++
 rtl/psk_frame_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/psk_seq_pkg.sv
// Shared types and helpers for the PSK frame sequencer: FSM state encoding,
// default symbol timing constants and a counter-width helper.
package psk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } psk_state_t;

  // Timing for the default build (100 MHz clock, 9600 sym/s, 8-bit BPSK words)
  localparam int CYCLE = 100000000 / 9600;
  localparam int SYMS  = 8;

  // Bits needed to count 0..n-1, never less than one
  function automatic int cnt_w(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/psk_sym_timer.sv
// Free-running symbol-period counter: tick on the last cycle of a period,
// strobe on the first; clr holds it at zero.
module psk_sym_timer
  import psk_seq_pkg::*;
#(
  parameter int PERIOD = 8,
  parameter int CNT_W  = cnt_w(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             strobe
);

  assign tick   = (count == CNT_W'(PERIOD - 1));
  assign strobe = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= '0;
    else if (clr || tick)  count <= '0;
    else                   count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/psk_frame_sequencer.sv
// Streams a frame of BRAM words out as BPSK/QPSK symbols with gap-free prefetch.
// Build option: PSK_DIFF_ENC_EN enables differential symbol encoding.
module psk_frame_sequencer
  import psk_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int BITS_PER_SYM = 1,
  parameter int CLK_FREQ     = 100000000,
  parameter int SYM_RATE     = 9600,
  parameter int RAM_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   frame_len,
  output logic                    busy,
  output logic                    done,
  output logic                    gen_en,
  output logic [BITS_PER_SYM-1:0] sym_out,
  output logic                    sym_strobe,
  output logic                    ram_clk,
  output logic                    ram_rst,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output psk_state_t              state_dbg
);

  localparam int CYC    = CLK_FREQ / SYM_RATE;
  localparam int NSYM   = DATA_WIDTH / BITS_PER_SYM;
  localparam int CNT_W  = cnt_w(CYC);
  localparam int SIDX_W = cnt_w(NSYM);
  localparam int BPS    = BITS_PER_SYM;

  if (BITS_PER_SYM != 1 && BITS_PER_SYM != 2) begin : g_bad_bps
    $error("BITS_PER_SYM must be 1 or 2");
  end
  if (DATA_WIDTH % BITS_PER_SYM != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of BITS_PER_SYM");
  end
  if (CYC < 4) begin : g_bad_cyc
    $error("CLK_FREQ/SYM_RATE must be at least 4");
  end
  if (RAM_LATENCY < 1 || RAM_LATENCY > 2) begin : g_bad_lat
    $error("RAM_LATENCY must be 1 or 2");
  end

  psk_state_t            state, state_nx;
  logic                  start_s1, start_s2, start_s3, start_rise;
  logic [1:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] len_q, word_idx;
  logic [SIDX_W-1:0]     sym_idx;
  logic [DATA_WIDTH-1:0] sr, pf;
  logic [CNT_W-1:0]      count;
  logic                  tick, strobe;
  logic                  accept, last_sym, last_word, more_pf, pf_issue, pf_cap;
  logic [BPS-1:0]        prev_sym;

  assign ram_clk     = clk;
  assign ram_rst     = 1'b0;
  assign ram_we      = 1'b0;
  assign ram_wr_data = '0;
  assign state_dbg   = state;
  assign busy        = (state != IDLE);
  assign gen_en      = (state == SEND);
  assign sym_strobe  = gen_en && strobe;

`ifdef PSK_DIFF_ENC_EN
  assign prev_sym = sym_out;
`else
  assign prev_sym = '0;
`endif

  psk_sym_timer #(.PERIOD(CYC), .CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != SEND),
    .count  (count),
    .tick   (tick),
    .strobe (strobe)
  );

  assign accept    = (state == IDLE) && start_rise && (frame_len != '0);
  assign last_sym  = (sym_idx == SIDX_W'(NSYM - 1));
  assign last_word = (word_idx == len_q - ADDR_WIDTH'(1));
  // The address register stops at the last word's address instead of running one past it
  assign more_pf   = (({1'b0, word_idx} + (ADDR_WIDTH + 1)'(2)) < {1'b0, len_q});
  assign pf_issue  = (state == SEND) && strobe && (sym_idx == '0) && !last_word;
  assign pf_cap    = (state == SEND) && (count == CNT_W'(RAM_LATENCY)) &&
                     (sym_idx == '0) && !last_word;
  assign ram_en    = (state == FETCH) || pf_issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_s3   <= 1'b0;
      start_rise <= 1'b0;
      state      <= IDLE;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      start_s3   <= start_s2;
      start_rise <= start_s2 && !start_s3;
      state      <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = FETCH;
      FETCH:   if (lat_cnt == 2'(RAM_LATENCY - 1)) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (tick && last_sym && last_word) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt  <= '0;
      len_q    <= '0;
      word_idx <= '0;
      sym_idx  <= '0;
      sr       <= '0;
      pf       <= '0;
      ram_addr <= '0;
      sym_out  <= '0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      lat_cnt <= (state == FETCH) ? lat_cnt + 2'd1 : 2'd0;
      if (!abort) begin
        case (state)
          IDLE: if (accept) begin
            len_q    <= frame_len;
            word_idx <= '0;
            ram_addr <= '0;
          end
          LOAD: begin
            // Differential history restarts from zero with every frame
            sr       <= ram_rd_data;
            sym_out  <= ram_rd_data[DATA_WIDTH-1 -: BPS];
            sym_idx  <= '0;
            ram_addr <= ADDR_WIDTH'(1);
          end
          SEND: begin
            if (pf_issue && more_pf) ram_addr <= ram_addr + ADDR_WIDTH'(1);
            if (pf_cap) pf <= ram_rd_data;
            if (tick) begin
              if (last_sym) begin
                if (last_word) begin
                  done <= 1'b1;
                end else begin
                  sr       <= pf;
                  sym_idx  <= '0;
                  word_idx <= word_idx + ADDR_WIDTH'(1);
                  sym_out  <= pf[DATA_WIDTH-1 -: BPS] + prev_sym;
                end
              end else begin
                sr      <= sr << BPS;
                sym_idx <= sym_idx + SIDX_W'(1);
                sym_out <= sr[DATA_WIDTH-1-BPS -: BPS] + prev_sym;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
